// File: rtl/block_text_pkg.sv
// ============================================================================
// block_text_pkg : op codes, ASCII constants, token lengths and encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package block_text_pkg;

  typedef enum logic [1:0] {
    OP_OPEN      = 2'd0,
    OP_CLOSE     = 2'd1,
    OP_CHAR      = 2'd2,
    OP_CLOSE_ALL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TOK_NONE  = 2'd0,
    TOK_BEGIN = 2'd1,
    TOK_END   = 2'd2,
    TOK_CHAR  = 2'd3
  } token_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_D     = 8'h64;

  localparam logic [2:0] BEGIN_LEN = 3'd6;
  localparam logic [2:0] END_LEN   = 3'd4;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) begin
      return c - 8'h20;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_token_rom.sv
// ============================================================================
// block_token_rom : maps (token, byte index) to the emitted byte
// Rev 1.0
// ============================================================================
`default_nettype none

module block_token_rom
  import block_text_pkg::*;
#(
  parameter bit UPPER = 1'b0
) (
  input  token_e     token_sel,
  input  logic [2:0] byte_idx,
  input  logic [7:0] raw_char,
  output logic [7:0] out_char
);

  logic [7:0] kw_char;
  logic [7:0] kw_cased;

  always_comb begin
    kw_char = 8'h00;
    case (token_sel)
      TOK_BEGIN: begin
        case (byte_idx)
          3'd0:    kw_char = CH_B;
          3'd1:    kw_char = CH_E;
          3'd2:    kw_char = CH_G;
          3'd3:    kw_char = CH_I;
          3'd4:    kw_char = CH_N;
          default: kw_char = CH_SPACE;
        endcase
      end
      TOK_END: begin
        case (byte_idx)
          3'd0:    kw_char = CH_E;
          3'd1:    kw_char = CH_N;
          3'd2:    kw_char = CH_D;
          default: kw_char = CH_SPACE;
        endcase
      end
      default: kw_char = 8'h00;
    endcase
  end

  generate
    if (UPPER) begin : g_upper
      assign kw_cased = to_upper(kw_char);
    end else begin : g_lower
      assign kw_cased = kw_char;
    end
  endgenerate

  // Raw bytes bypass case conversion entirely.
  assign out_char = (token_sel == TOK_CHAR) ? raw_char : kw_cased;

endmodule

`default_nettype wire

// File: rtl/block_token_emitter.sv
// ============================================================================
// block_token_emitter : command-driven keyword byte-stream generator
// Rev 1.0
// ============================================================================
`default_nettype none

module block_token_emitter
  import block_text_pkg::*;
#(
  parameter int DEPTH_W = 32,
  parameter bit UPPER   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [7:0]         cmd_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_char,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  token_e               token_q, token_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           char_q, char_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 err_q, err_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic accept;
  logic fire;
  logic last_byte;

  assign accept = cmd_valid && cmd_ready_q;
  assign fire   = out_valid_q && out_ready;

  always_comb begin
    last_byte = 1'b0;
    case (token_q)
      TOK_BEGIN: last_byte = (idx_q == BEGIN_LEN - 3'd1);
      TOK_END:   last_byte = (idx_q == END_LEN - 3'd1);
      TOK_CHAR:  last_byte = 1'b1;
      default:   last_byte = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    token_d     = token_q;
    idx_d       = idx_q;
    char_d      = char_q;
    depth_d     = depth_q;
    err_d       = err_q;
    cmd_ready_d = cmd_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_OPEN: begin
              if (depth_q == DEPTH_MAX) begin
                err_d = 1'b1;
              end else begin
                depth_d     = depth_q + DEPTH_ONE;
                state_d     = ST_EMIT;
                token_d     = TOK_BEGIN;
                idx_d       = 3'd0;
                out_valid_d = 1'b1;
                cmd_ready_d = 1'b0;
              end
            end
            OP_CLOSE: begin
              if (depth_q == '0) begin
                err_d = 1'b1;
              end else begin
                depth_d     = depth_q - DEPTH_ONE;
                state_d     = ST_EMIT;
                token_d     = TOK_END;
                idx_d       = 3'd0;
                out_valid_d = 1'b1;
                cmd_ready_d = 1'b0;
              end
            end
            OP_CHAR: begin
              state_d     = ST_EMIT;
              token_d     = TOK_CHAR;
              char_d      = cmd_char;
              idx_d       = 3'd0;
              out_valid_d = 1'b1;
              cmd_ready_d = 1'b0;
            end
            OP_CLOSE_ALL: begin
              if (depth_q != '0) begin
                state_d     = ST_DRAIN;
                token_d     = TOK_END;
                idx_d       = 3'd0;
                out_valid_d = 1'b1;
                cmd_ready_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_EMIT: begin
        if (fire) begin
          if (last_byte) begin
            state_d     = ST_IDLE;
            token_d     = TOK_NONE;
            idx_d       = 3'd0;
            out_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DRAIN: begin
        // Each "end " closes one level when its trailing space is taken.
        if (fire) begin
          if (last_byte) begin
            depth_d = depth_q - DEPTH_ONE;
            idx_d   = 3'd0;
            if (depth_q == DEPTH_ONE) begin
              state_d     = ST_IDLE;
              token_d     = TOK_NONE;
              out_valid_d = 1'b0;
              cmd_ready_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        token_d     = TOK_NONE;
        idx_d       = 3'd0;
        out_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      token_q     <= TOK_NONE;
      idx_q       <= 3'd0;
      char_q      <= 8'h00;
      depth_q     <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      token_q     <= token_d;
      idx_q       <= idx_d;
      char_q      <= char_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  block_token_rom #(
    .UPPER(UPPER)
  ) u_rom (
    .token_sel(token_q),
    .byte_idx (idx_q),
    .raw_char (char_q),
    .out_char (out_char)
  );

  assign cmd_ready = cmd_ready_q;
  assign out_valid = out_valid_q;
  assign depth     = depth_q;
  assign balanced  = (depth_q == '0);
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_block_token_emitter.sv
// Bench for block_token_emitter: directed scenarios plus random commands checked
// against a byte-queue model of the keyword stream.
`default_nettype none
`timescale 1ns/1ps

module tb_block_token_emitter;
  import block_text_pkg::*;

  localparam int DW = 2;
  localparam int MAXD = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, out_valid, out_ready, balanced, err;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_char, out_char;
  logic [DW-1:0] depth;

  logic          u_cmd_valid, u_cmd_ready, u_out_valid, u_balanced, u_err;
  logic [1:0]    u_cmd_op;
  logic [7:0]    u_out_char;
  logic [31:0]   u_depth;

  always #5 clk = ~clk;

  block_token_emitter #(.DEPTH_W(DW), .UPPER(1'b0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_char(cmd_char), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .depth(depth), .balanced(balanced), .err(err)
  );

  block_token_emitter #(.DEPTH_W(32), .UPPER(1'b1)) dut_u (
    .clk(clk), .reset(reset), .cmd_valid(u_cmd_valid), .cmd_ready(u_cmd_ready),
    .cmd_op(u_cmd_op), .cmd_char(8'h00), .out_valid(u_out_valid), .out_ready(1'b1),
    .out_char(u_out_char), .depth(u_depth), .balanced(u_balanced), .err(u_err)
  );

  int checks = 0;
  int errors = 0;
  int mdepth = 0;
  bit merr   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] ch, input bit rnd_ready);
    logic [7:0] exp_q[$];
    string      tok;
    int         idx, guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    case (op)
      2'd0: if (mdepth == MAXD) merr = 1'b1;
            else begin
              mdepth++;
              tok = "begin ";
              for (int k = 0; k < tok.len(); k++) exp_q.push_back(tok[k]);
            end
      2'd1: if (mdepth == 0) merr = 1'b1;
            else begin
              mdepth--;
              tok = "end ";
              for (int k = 0; k < tok.len(); k++) exp_q.push_back(tok[k]);
            end
      2'd2: exp_q.push_back(ch);
      default: begin
        tok = "end ";
        for (int j = 0; j < mdepth; j++)
          for (int k = 0; k < tok.len(); k++) exp_q.push_back(tok[k]);
      end
    endcase
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_char  = ch;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_char  = 8'($urandom);
    check("err_after_accept", err, merr);
    idx   = 0;
    guard = 0;
    while (idx < exp_q.size() && guard < 400) begin
      check("out_valid_busy", out_valid, 1);
      check("out_char", out_char, exp_q[idx]);
      check("depth_busy", depth, mdepth);
      check("cmd_ready_busy", cmd_ready, 0);
      out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      guard++;
      if (out_ready) begin
        if (op == 2'd3 && exp_q[idx] == 8'h20) mdepth--;
        idx++;
      end
    end
    check("bytes_emitted", idx, exp_q.size());
    check("out_valid_idle", out_valid, 0);
    check("cmd_ready_idle", cmd_ready, 1);
    check("depth_idle", depth, mdepth);
    check("balanced", balanced, (mdepth == 0));
    check("err_idle", err, merr);
    out_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [7:0] got[$];
    string      exp_u;
    int         ni, r;
    logic [7:0] ch;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_char = 8'h00; out_ready = 1'b0;
    u_cmd_valid = 1'b0; u_cmd_op = 2'd0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 0);
    check("rst_depth", depth, 0);
    check("rst_balanced", balanced, 1);
    check("rst_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // "begin x end "
    run_cmd(2'd0, 8'h00, 1'b0);
    run_cmd(2'd2, "x", 1'b0);
    run_cmd(2'd1, 8'h00, 1'b0);
    // "begin begin end end "
    run_cmd(2'd0, 8'h00, 1'b0);
    run_cmd(2'd0, 8'h00, 1'b0);
    run_cmd(2'd3, 8'h00, 1'b0);
    // illegal close, then a normal open with err sticky; then stalled output
    run_cmd(2'd1, 8'h00, 1'b0);
    run_cmd(2'd0, 8'h00, 1'b0);
    run_cmd(2'd0, 8'h00, 1'b1);
    run_cmd(2'd3, 8'h00, 1'b1);
    run_cmd(2'd3, 8'h00, 1'b0);

    // reset after the third byte of "begin "
    run_cmd(2'd2, "q", 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    check("pre_rst_b", out_char, 8'h62);
    @(negedge clk);
    check("pre_rst_e", out_char, 8'h65);
    @(negedge clk);
    check("pre_rst_g", out_char, 8'h67);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_depth", depth, 0);
    check("async_rst_balanced", balanced, 1);
    check("async_rst_err", err, 0);
    check("async_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    reset  = 1'b0;
    mdepth = 0;
    merr   = 1'b0;
    @(negedge clk);
    run_cmd(2'd0, 8'h00, 1'b0);
    run_cmd(2'd1, 8'h00, 1'b0);

    // random command mix; small depth counter exercises overflow
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      ch = ($urandom_range(0, 4) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
      if (r < 4)      run_cmd(2'd0, ch, 1'b1);
      else if (r < 7) run_cmd(2'd1, ch, 1'b1);
      else if (r < 9) run_cmd(2'd2, ch, 1'b1);
      else            run_cmd(2'd3, ch, 1'b1);
    end

    // uppercase instance: OPEN, CLOSE
    exp_u = "BEGIN END ";
    ni = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (u_out_valid) got.push_back(u_out_char);
      u_cmd_valid = 1'b0;
      if (u_cmd_ready && ni < 2) begin
        u_cmd_valid = 1'b1;
        u_cmd_op    = (ni == 0) ? 2'd0 : 2'd1;
        ni++;
      end
    end
    u_cmd_valid = 1'b0;
    check("upper_len", got.size(), exp_u.len());
    for (int k = 0; k < exp_u.len() && k < got.size(); k++)
      check("upper_char", got[k], exp_u[k]);
    check("upper_depth", u_depth, 0);
    check("upper_balanced", u_balanced, 1);
    check("upper_err", u_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
